// File: rtl/keypad_entry_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry_sequencer
// Description : Buffers up to six keypad digits with backspace/cancel editing.
//               On enter with a full buffer it replays the digits as three
//               registered pairs (LOAD1..LOAD3), then a JUDGE beat, then pulses
//               done. Enter on a short buffer pulses err and discards the entry.
//               Optional macro ENTRY_TIMEOUT_EN adds an idle timeout that
//               discards a partial entry after TIMEOUT_CYCLES quiet cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] inA,
    output logic [3:0] inB,
    output logic       a0,
    output logic       a1,
    output logic       ld_vld,
    output logic       busy,
    output logic [2:0] digit_cnt,
    output logic       done,
    output logic       err
);

    // Elaboration-time guard on the timeout range.
    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > (1 << 24))) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 2..2^24");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_LOAD1   = 3'd2,
        S_LOAD2   = 3'd3,
        S_LOAD3   = 3'd4,
        S_JUDGE   = 3'd5
    } state_t;

    localparam logic [3:0] c_KEY_BKSP   = 4'hA;
    localparam logic [3:0] c_KEY_ENTER  = 4'hB;
    localparam logic [3:0] c_KEY_CANCEL = 4'hC;
    localparam logic [2:0] c_FULL       = 3'd6;

    state_t          state_q, state_d;
    logic [5:0][3:0] digits_q, digits_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [3:0]      inA_q, inA_d;
    logic [3:0]      inB_q, inB_d;
    logic [1:0]      sel_q, sel_d;
    logic            ld_vld_q, ld_vld_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            key_accepted;

`ifdef ENTRY_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] c_TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmr_q, tmr_d;
`endif

    // State, buffer and registered outputs; clr overrides everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            digits_q <= '0;
            cnt_q    <= '0;
            inA_q    <= '0;
            inB_q    <= '0;
            sel_q    <= '0;
            ld_vld_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            cnt_q    <= cnt_d;
            inA_q    <= inA_d;
            inB_q    <= inB_d;
            sel_q    <= sel_d;
            ld_vld_q <= ld_vld_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    // Idle-cycle counter for partial entries.
    always_ff @(posedge clk) begin
        if (clr) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`endif

    // Next-state, buffer editing and next-output decode.
    always_comb begin
        state_d      = state_q;
        digits_d     = digits_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        key_accepted = 1'b0;
        inA_d        = '0;
        inB_d        = '0;
        sel_d        = '0;
        ld_vld_d     = 1'b0;
        busy_d       = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
        tmr_d        = '0;
`endif

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (key_valid) begin
                    case (key_code)
                        c_KEY_BKSP: begin
                            if (cnt_q != 3'd0) begin
                                key_accepted                      = 1'b1;
                                digits_d[3'(cnt_q - 3'd1)]        = 4'h0;
                                cnt_d                             = cnt_q - 3'd1;
                                state_d = (cnt_q == 3'd1) ? S_IDLE : S_COLLECT;
                            end
                        end
                        c_KEY_ENTER: begin
                            if (cnt_q == c_FULL) begin
                                state_d = S_LOAD1;
                            end else begin
                                err_d    = 1'b1;
                                cnt_d    = '0;
                                digits_d = '0;
                                state_d  = S_IDLE;
                            end
                        end
                        c_KEY_CANCEL: begin
                            key_accepted = 1'b1;
                            cnt_d        = '0;
                            digits_d     = '0;
                            state_d      = S_IDLE;
                        end
                        4'hD, 4'hE, 4'hF: begin
                            // Unused codes are not events at all.
                        end
                        default: begin
                            // Digits 0-9; a seventh digit is silently dropped.
                            if (cnt_q < c_FULL) begin
                                key_accepted      = 1'b1;
                                digits_d[cnt_q]   = key_code;
                                cnt_d             = cnt_q + 3'd1;
                                state_d           = S_COLLECT;
                            end
                        end
                    endcase
                end
            end
            S_LOAD1: state_d = S_LOAD2;
            S_LOAD2: state_d = S_LOAD3;
            S_LOAD3: state_d = S_JUDGE;
            S_JUDGE: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                digits_d = '0;
                done_d   = 1'b1;
            end
            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                digits_d = '0;
            end
        endcase

`ifdef ENTRY_TIMEOUT_EN
        // Only a partial entry that stays in COLLECT without an accepted key
        // ages; an accepted key in the expiry cycle wins over the timeout.
        if ((state_q == S_COLLECT) && (state_d == S_COLLECT) && !key_accepted) begin
            if (tmr_q == c_TMR_LAST) begin
                tmr_d    = '0;
                cnt_d    = '0;
                digits_d = '0;
                state_d  = S_IDLE;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end
`else
        key_accepted = key_accepted;
`endif

        // Outputs are decoded from the next state so they register alongside it.
        case (state_d)
            S_LOAD1: begin
                ld_vld_d = 1'b1;
                busy_d   = 1'b1;
                sel_d    = 2'd0;
                inA_d    = digits_q[0];
                inB_d    = digits_q[1];
            end
            S_LOAD2: begin
                ld_vld_d = 1'b1;
                busy_d   = 1'b1;
                sel_d    = 2'd1;
                inA_d    = digits_q[2];
                inB_d    = digits_q[3];
            end
            S_LOAD3: begin
                ld_vld_d = 1'b1;
                busy_d   = 1'b1;
                sel_d    = 2'd2;
                inA_d    = digits_q[4];
                inB_d    = digits_q[5];
            end
            S_JUDGE: begin
                ld_vld_d = 1'b1;
                busy_d   = 1'b1;
                sel_d    = 2'd3;
            end
            default: begin
                ld_vld_d = 1'b0;
            end
        endcase
    end

    assign inA       = inA_q;
    assign inB       = inB_q;
    assign a0        = sel_q[0];
    assign a1        = sel_q[1];
    assign ld_vld    = ld_vld_q;
    assign busy      = busy_q;
    assign digit_cnt = cnt_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire
